// File: rtl/ncl4_pkg.sv
// Shared types and helpers for the four-rail NCL synchronous sink.
package ncl4_pkg;

    localparam int RAIL_W = 4;
    localparam logic [RAIL_W-1:0] NULL_PATTERN = 4'b0000;

    typedef enum logic {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        P_NULL    = 2'd0,
        P_DATA    = 2'd1,
        P_ILLEGAL = 2'd2
    } pclass_t;

    // Rail k high decodes to k; non-one-hot inputs decode to 0.
    function automatic logic [1:0] onehot_dec(input logic [RAIL_W-1:0] r);
        logic [1:0] v;
        v = 2'd0;
        case (r)
            4'b0001: v = 2'd0;
            4'b0010: v = 2'd1;
            4'b0100: v = 2'd2;
            4'b1000: v = 2'd3;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    // All-zero is NULL, exactly one bit is DATA, anything else is illegal.
    function automatic pclass_t classify(input logic [RAIL_W-1:0] r);
        pclass_t c;
        if (r == NULL_PATTERN)
            c = P_NULL;
        else if ((r & (r - 4'd1)) == 4'd0)
            c = P_DATA;
        else
            c = P_ILLEGAL;
        return c;
    endfunction

endpackage

// File: rtl/ncl4_sink_fifo.sv
// Small synchronous FIFO for decoded 2-bit values. Full/empty come from the
// registered level only, so a same-cycle pop never makes room for a push.
module ncl4_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [1:0]    data_i,
    input  logic          pop_i,
    output logic [1:0]    data_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][1:0] mem_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q;
    logic                  do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign valid_o = (level_q != '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage, wrapping pointers and occupancy; contents cleared on reset so the head reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/ncl4_sync_sink.sv
// Terminal consumer of a four-rail NCL stream: synchronises the rails, filters
// them for stability, runs the DATA/NULL completion handshake and queues the
// decoded values for a valid/ready consumer.
module ncl4_sync_sink
    import ncl4_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       init_n,
    input  logic [3:0]                 rail_i,
    output logic                       comp_o,
    output logic                       out_valid,
    output logic [1:0]                 out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       err_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][RAIL_W-1:0] sync_q;
    logic [RAIL_W-1:0]                  s, prev_q;
    logic [CW-1:0]                      cnt_q, cnt_d;
    logic                               accepted;
    pclass_t                            pclass;
    state_t                             state_q, state_d;
    logic                               err_q, err_d;
    logic                               push, fifo_full;

    assign s      = sync_q[SYNC_STAGES-1];
    assign pclass = classify(s);

    // Per-rail flop chain; index 0 takes the raw asynchronous rails.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], rail_i};
    end

    // Run length of identical samples including this one, saturating; the
    // pattern stays accepted for as long as it is held.
    always_comb begin
        cnt_d = cnt_q;
        if (s != prev_q)
            cnt_d = CW'(1);
        else if (cnt_q != CW'(STABLE_CYCLES))
            cnt_d = cnt_q + CW'(1);
        accepted = (cnt_d == CW'(STABLE_CYCLES));
    end

    // Previous sample and run-length register for the stability filter.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= s;
            cnt_q  <= cnt_d;
        end
    end

    // Handshake FSM: a DATA push is held off while the FIFO is full, which
    // keeps comp_o low and stalls the upstream ring.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        push    = 1'b0;
        if (accepted) begin
            case (pclass)
                P_DATA: begin
                    if (state_q == WAIT_DATA && !fifo_full) begin
                        push    = 1'b1;
                        state_d = WAIT_NULL;
                    end
                end
                P_NULL: begin
                    if (state_q == WAIT_NULL)
                        state_d = WAIT_DATA;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    // FSM state and sticky error flag.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q <= WAIT_DATA;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign comp_o = (state_q == WAIT_NULL);
    assign err_o  = err_q;

    ncl4_sink_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (init_n),
        .push_i  (push),
        .data_i  (onehot_dec(s)),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

endmodule

// File: tb/tb_ncl4_sync_sink.sv
// Directed bench for ncl4_sync_sink with default parameters.
module tb_ncl4_sync_sink;

    localparam int DEPTH = 4, SYNC = 2, STAB = 2;

    logic       clk = 1'b0;
    logic       init_n = 1'b0;
    logic [3:0] rail = 4'b0000;
    logic       comp, ovalid, oready = 1'b0, err;
    logic [1:0] odata;
    logic [2:0] level;

    int total = 0, bad = 0;
    logic [1:0] pops[$];

    ncl4_sync_sink #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB)) dut (
        .clk       (clk),
        .init_n    (init_n),
        .rail_i    (rail),
        .comp_o    (comp),
        .out_valid (ovalid),
        .out_data  (odata),
        .out_ready (oready),
        .level_o   (level),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    // Record every transfer the consumer takes.
    always @(posedge clk)
        if (init_n && ovalid && oready) pops.push_back(odata);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_comp(input logic val, input int budget, input string tag);
        int n = 0;
        while (comp !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, comp, val);
    endtask

    task automatic wavefront(input logic [3:0] r, input string tag);
        rail = r;
        wait_comp(1'b1, SYNC + STAB + 2, {tag, "_up"});
        rail = 4'b0000;
        wait_comp(1'b0, SYNC + STAB + 2, {tag, "_dn"});
    endtask

    initial begin
        logic [1:0] exp5[5];
        exp5 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset, then NULL held: everything quiet.
        cyc(3);
        chk("rst_state", {comp, ovalid, level, err}, 32'h0);
        init_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("null_idle", {comp, ovalid, level, err}, 32'h0);
        end

        // Single wavefront with a ready consumer.
        oready = 1'b1;
        rail = 4'b0010;
        wait_comp(1'b1, SYNC + STAB + 1, "single_up");
        rail = 4'b0000;
        wait_comp(1'b0, SYNC + STAB + 2, "single_dn");
        cyc(4);
        chk("single_npop", pops.size(), 1);
        if (pops.size() == 1) chk("single_data", pops[0], 2'd1);
        pops.delete();

        // Fill the FIFO, then a fifth DATA is held off by backpressure.
        oready = 1'b0;
        wavefront(4'b0001, "fill0");
        wavefront(4'b0010, "fill1");
        wavefront(4'b0100, "fill2");
        wavefront(4'b1000, "fill3");
        chk("full_level", level, 3'd4);
        rail = 4'b0001;
        cyc(10);
        chk("full_stall_comp", comp, 1'b0);
        chk("full_stall_level", level, 3'd4);
        oready = 1'b1;
        wait_comp(1'b1, 10, "bp_release_up");
        rail = 4'b0000;
        wait_comp(1'b0, SYNC + STAB + 2, "bp_release_dn");
        cyc(6);
        chk("drain_npop", pops.size(), 5);
        for (int i = 0; i < 5 && i < pops.size(); i++)
            chk($sformatf("drain_pop%0d", i), pops[i], exp5[i]);
        chk("drain_level", level, 3'd0);
        chk("drain_valid", ovalid, 1'b0);
        pops.delete();

        // Illegal pattern after an accepted DATA.
        oready = 1'b0;
        rail = 4'b0010;
        wait_comp(1'b1, SYNC + STAB + 2, "ill_data_up");
        chk("ill_pre_level", level, 3'd1);
        rail = 4'b0110;
        cyc(5);
        chk("ill_err", err, 1'b1);
        chk("ill_level", level, 3'd1);
        chk("ill_comp", comp, 1'b1);
        rail = 4'b0000;
        wait_comp(1'b0, SYNC + STAB + 2, "ill_null_dn");
        cyc(3);
        chk("ill_err_sticky", err, 1'b1);
        oready = 1'b1;
        cyc(3);
        chk("ill_drain_npop", pops.size(), 1);
        if (pops.size() == 1) chk("ill_drain_data", pops[0], 2'd1);
        pops.delete();

        // One-cycle glitch is rejected by the stability filter.
        oready = 1'b0;
        rail = 4'b0100;
        cyc(1);
        rail = 4'b0000;
        cyc(10);
        chk("glitch_comp", comp, 1'b0);
        chk("glitch_level", level, 3'd0);

        // Asynchronous reset in the middle of a wavefront.
        wavefront(4'b0001, "mid0");
        rail = 4'b0010;
        wait_comp(1'b1, SYNC + STAB + 2, "mid1_up");
        chk("mid_level", level, 3'd2);
        #2 init_n = 1'b0;
        #1 chk("async_rst", {comp, ovalid, level, err}, 32'h0);
        rail = 4'b0000;
        @(negedge clk);
        init_n = 1'b1;
        cyc(10);
        chk("post_rst", {comp, ovalid, level, err}, 32'h0);
        chk("post_rst_npop", pops.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
